// File: rtl/clock_pkg.sv
// Shared BCD types, field limits and helpers for the time-of-day counter.
package clock_pkg;

    typedef logic [7:0] bcd2_t;

    localparam bcd2_t BCD_MAX_SEC  = 8'h59;
    localparam bcd2_t BCD_MAX_MIN  = 8'h59;
    localparam bcd2_t BCD_MAX_HOUR = 8'h23;

    // True when both nibbles are decimal digits and the value does not exceed max.
    function automatic logic bcd_valid(input bcd2_t value, input bcd2_t max);
        return (value[7:4] <= 4'd9) && (value[3:0] <= 4'd9) && (value <= max);
    endfunction

    function automatic bcd2_t bcd_inc(input bcd2_t value, input bcd2_t max);
        bcd2_t r;
        if (value == max)
            r = 8'h00;
        else if (value[3:0] == 4'd9)
            r = {value[7:4] + 4'd1, 4'd0};
        else
            r = {value[7:4], value[3:0] + 4'd1};
        return r;
    endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD modulo counter with synchronous load; carry flags the wrap to 00.
module bcd_mod_counter
    import clock_pkg::*;
#(
    parameter bcd2_t MAX  = 8'h59,
    parameter bcd2_t INIT = 8'h00
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  inc,
    input  logic  load,
    input  bcd2_t load_val,
    output bcd2_t count,
    output logic  carry
);

    bcd2_t r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_count <= INIT;
        else if (load)
            r_count <= load_val;
        else if (inc)
            r_count <= bcd_inc(r_count, MAX);
    end

    assign count = r_count;
    assign carry = inc & (r_count == MAX);

endmodule

// File: rtl/time_keeper.sv
// 24-hour BCD time-of-day keeper driven by a 1 Hz square wave, with set-time load and daily alarm.
module time_keeper
    import clock_pkg::*;
#(
    parameter bcd2_t INIT_HOUR = 8'h00,
    parameter bcd2_t INIT_MIN  = 8'h00,
    parameter bcd2_t INIT_SEC  = 8'h00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sec_in,
    input  logic       set_valid,
    input  logic [7:0] set_hour,
    input  logic [7:0] set_min,
    input  logic       alarm_en,
    input  logic [7:0] alarm_hour,
    input  logic [7:0] alarm_min,
    output logic [7:0] hour_bcd,
    output logic [7:0] min_bcd,
    output logic [7:0] sec_bcd,
    output logic       tick_out,
    output logic       day_pulse,
    output logic       alarm,
    output logic       set_err
);

    logic  r_s1, r_s2, r_s3;
    logic  r_tick, r_day, r_alarm, r_err;
    logic  w_tick, w_set_ok, w_load, w_adv;
    logic  w_sec_carry, w_min_carry, w_hour_carry, w_alarm_hit;
    bcd2_t w_sec, w_min, w_hour, w_nxt_min, w_nxt_hour;

    // Flops reset high so a sec_in already high at reset release is not seen as an edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1 <= 1'b1;
            r_s2 <= 1'b1;
            r_s3 <= 1'b1;
        end else begin
            r_s1 <= sec_in;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign w_tick   = r_s2 & ~r_s3;
    assign w_set_ok = bcd_valid(set_hour, BCD_MAX_HOUR) && bcd_valid(set_min, BCD_MAX_MIN);
    assign w_load   = set_valid & w_set_ok;
    assign w_adv    = w_tick & ~set_valid;

    bcd_mod_counter #(.MAX(BCD_MAX_SEC), .INIT(INIT_SEC)) u_sec (
        .clk(clk), .rst(rst), .inc(w_adv), .load(w_load), .load_val(8'h00),
        .count(w_sec), .carry(w_sec_carry)
    );

    bcd_mod_counter #(.MAX(BCD_MAX_MIN), .INIT(INIT_MIN)) u_min (
        .clk(clk), .rst(rst), .inc(w_sec_carry), .load(w_load), .load_val(set_min),
        .count(w_min), .carry(w_min_carry)
    );

    bcd_mod_counter #(.MAX(BCD_MAX_HOUR), .INIT(INIT_HOUR)) u_hour (
        .clk(clk), .rst(rst), .inc(w_min_carry), .load(w_load), .load_val(set_hour),
        .count(w_hour), .carry(w_hour_carry)
    );

    // The alarm can only match on a seconds wrap, so compare against the post-tick minute/hour.
    assign w_nxt_min   = bcd_inc(w_min, BCD_MAX_MIN);
    assign w_nxt_hour  = w_min_carry ? bcd_inc(w_hour, BCD_MAX_HOUR) : w_hour;
    assign w_alarm_hit = alarm_en & w_sec_carry & (w_nxt_min == alarm_min) & (w_nxt_hour == alarm_hour);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tick  <= 1'b0;
            r_day   <= 1'b0;
            r_alarm <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_tick  <= w_adv;
            r_day   <= w_hour_carry;
            r_alarm <= w_alarm_hit;
            r_err   <= set_valid & ~w_set_ok;
        end
    end

    assign hour_bcd  = w_hour;
    assign min_bcd   = w_min;
    assign sec_bcd   = w_sec;
    assign tick_out  = r_tick;
    assign day_pulse = r_day;
    assign alarm     = r_alarm;
    assign set_err   = r_err;

endmodule

// File: tb/tb_time_keeper.sv
// Randomised and directed bench for time_keeper against a seconds-of-day reference model.
module tb_time_keeper;

    localparam int INIT_TOD = 0;

    logic       clk = 1'b0;
    logic       rst, sec_in, set_valid, alarm_en;
    logic [7:0] set_hour, set_min, alarm_hour, alarm_min;
    logic [7:0] hour_bcd, min_bcd, sec_bcd;
    logic       tick_out, day_pulse, alarm, set_err;

    always #10 clk = ~clk;

    time_keeper #(.INIT_HOUR(8'h00), .INIT_MIN(8'h00), .INIT_SEC(8'h00)) dut (
        .clk(clk), .rst(rst), .sec_in(sec_in), .set_valid(set_valid),
        .set_hour(set_hour), .set_min(set_min), .alarm_en(alarm_en),
        .alarm_hour(alarm_hour), .alarm_min(alarm_min),
        .hour_bcd(hour_bcd), .min_bcd(min_bcd), .sec_bcd(sec_bcd),
        .tick_out(tick_out), .day_pulse(day_pulse), .alarm(alarm), .set_err(set_err)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: time as seconds of day, pending ticks as edge numbers.
    int m_tod;
    bit m_prev;
    int m_edge = 0;
    int m_pend[$];
    bit e_tick, e_day, e_alarm, e_err;
    int n_tick, n_day, n_alarm, n_err;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] to_bcd(input int v);
        return 8'(((v / 10) * 16) + (v % 10));
    endfunction

    // Decimal value of a BCD byte, or -1 when it is not a legal value up to max.
    function automatic int bcd_dec(input logic [7:0] b, input int max);
        int v;
        if (b[7:4] > 4'd9 || b[3:0] > 4'd9) return -1;
        v = int'(b[7:4]) * 10 + int'(b[3:0]);
        if (v > max) return -1;
        return v;
    endfunction

    task automatic model_reset();
        m_tod   = INIT_TOD;
        m_prev  = 1'b1;
        m_pend.delete();
        e_tick  = 1'b0;
        e_day   = 1'b0;
        e_alarm = 1'b0;
        e_err   = 1'b0;
    endtask

    task automatic model_edge();
        bit rise, tick;
        int h, m, ah, am;
        m_edge++;
        if (rst) begin
            model_reset();
            return;
        end
        e_tick  = 1'b0;
        e_day   = 1'b0;
        e_alarm = 1'b0;
        e_err   = 1'b0;
        tick = (m_pend.size() > 0) && (m_pend[0] == m_edge);
        if (tick) void'(m_pend.pop_front());
        rise   = sec_in && !m_prev;
        m_prev = sec_in;
        if (rise) m_pend.push_back(m_edge + 2);
        if (set_valid) begin
            h = bcd_dec(set_hour, 23);
            m = bcd_dec(set_min, 59);
            if (h >= 0 && m >= 0) m_tod = h * 3600 + m * 60;
            else e_err = 1'b1;
        end else if (tick) begin
            m_tod  = (m_tod + 1) % 86400;
            e_tick = 1'b1;
            e_day  = (m_tod == 0);
            ah = bcd_dec(alarm_hour, 23);
            am = bcd_dec(alarm_min, 59);
            e_alarm = alarm_en && ah >= 0 && am >= 0 && (m_tod == ah * 3600 + am * 60);
        end
    endtask

    task automatic compare_all();
        check("hour", hour_bcd, to_bcd(m_tod / 3600));
        check("min", min_bcd, to_bcd((m_tod / 60) % 60));
        check("sec", sec_bcd, to_bcd(m_tod % 60));
        check("tick_out", tick_out, e_tick);
        check("day_pulse", day_pulse, e_day);
        check("alarm", alarm, e_alarm);
        check("set_err", set_err, e_err);
        n_tick  += int'(tick_out);
        n_day   += int'(day_pulse);
        n_alarm += int'(alarm);
        n_err   += int'(set_err);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            sec_in = 1'b1; step(); step();
            sec_in = 1'b0; step(); step();
        end
    endtask

    task automatic do_set(input logic [7:0] h, input logic [7:0] m);
        set_hour  = h;
        set_min   = m;
        set_valid = 1'b1;
        step();
        set_valid = 1'b0;
        step();
    endtask

    initial begin
        rst = 1'b1; sec_in = 1'b1; set_valid = 1'b0; set_hour = 8'h00; set_min = 8'h00;
        alarm_en = 1'b0; alarm_hour = 8'h00; alarm_min = 8'h00;
        n_tick = 0; n_day = 0; n_alarm = 0; n_err = 0;
        #1 model_reset();
        repeat (3) step();
        rst = 1'b0;

        // Held-high sec_in at release, then two real edges.
        repeat (4) step();
        n_tick = 0;
        sec_in = 1'b0; step(); step();
        tick(2);
        check("reset_two_ticks", n_tick, 2);
        check("reset_sec_02", sec_bcd, 8'h02);

        do_set(8'h23, 8'h59);
        check("set_2359", {hour_bcd, min_bcd, sec_bcd}, 24'h235900);
        tick(1);
        check("set_2359_tick", {hour_bcd, min_bcd, sec_bcd}, 24'h235901);
        n_day = 0;
        tick(58);
        tick(1);
        check("rollover", {hour_bcd, min_bcd, sec_bcd}, 24'h000000);
        check("rollover_day", n_day, 1);

        do_set(8'h00, 8'h09); tick(60);
        check("carry_min", {hour_bcd, min_bcd, sec_bcd}, 24'h001000);
        do_set(8'h09, 8'h59); tick(60);
        check("carry_hour", {hour_bcd, min_bcd, sec_bcd}, 24'h100000);

        n_err = 0;
        do_set(8'h24, 8'h00);
        do_set(8'h12, 8'h60);
        do_set(8'h12, 8'h1A);
        check("bad_set_time", {hour_bcd, min_bcd, sec_bcd}, 24'h100000);
        check("bad_set_errs", n_err, 3);
        do_set(8'h12, 8'h34);
        check("good_set", {hour_bcd, min_bcd, sec_bcd}, 24'h123400);
        check("good_set_noerr", n_err, 3);

        alarm_en = 1'b1; alarm_hour = 8'h12; alarm_min = 8'h35; n_alarm = 0;
        tick(59);
        check("alarm_quiet", n_alarm, 0);
        tick(1);
        check("alarm_fire", n_alarm, 1);
        check("alarm_time", {hour_bcd, min_bcd, sec_bcd}, 24'h123500);
        alarm_en = 1'b0;
        do_set(8'h12, 8'h34); tick(60);
        check("alarm_disabled", n_alarm, 1);

        // Tick lands on the same edge as a valid set.
        n_tick = 0;
        sec_in = 1'b1; step(); step();
        set_hour = 8'h05; set_min = 8'h43; set_valid = 1'b1; step();
        set_valid = 1'b0; sec_in = 1'b0; step(); step();
        check("collide_time", {hour_bcd, min_bcd, sec_bcd}, 24'h054300);
        check("collide_notick", n_tick, 0);

        // Asynchronous reset in the middle of a cycle.
        tick(3);
        rst = 1'b1;
        #1;
        model_reset();
        compare_all();
        check("async_rst", {hour_bcd, min_bcd, sec_bcd}, 24'h000000);
        repeat (2) step();
        rst = 1'b0;

        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 3) == 0) sec_in = ~sec_in;
            set_valid = ($urandom_range(0, 40) == 0);
            if (set_valid) begin
                case ($urandom_range(0, 2))
                    0: begin set_hour = to_bcd(int'($urandom_range(0, 23))); set_min = to_bcd(int'($urandom_range(0, 59))); end
                    1: begin set_hour = 8'h23; set_min = 8'h59; end
                    default: begin set_hour = 8'($urandom); set_min = 8'($urandom); end
                endcase
            end
            if ($urandom_range(0, 50) == 0) begin
                alarm_en   = 1'($urandom_range(0, 1));
                alarm_hour = to_bcd(m_tod / 3600);
                alarm_min  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : to_bcd(((m_tod / 60) + 1) % 60);
            end
            step();
        end
        set_valid = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
